h3_hash_scheduler: RTL and testbench
====================================

H3_HASH_SCHEDULER -- requirements
Module: h3_hash_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- KEY_WIDTH, 32, key width in bits.
- HASH_ADR_WIDTH, 5, hash address width, which is also the number of matrix rows.
- NUM_REQ, 4, number of requesters (>=2).
- ID_WIDTH, $clog2(NUM_REQ), derived; not overridden.
- ROW_WIDTH, $clog2(HASH_ADR_WIDTH), derived; not overridden.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester key valid.
- req_key_i  in  KEY_WIDTH x NUM_REQ (unpacked array)  per-requester key.
- req_ready_o  out  NUM_REQ  per-requester accept.
- cfg_we_i  in  1  matrix row write request.
- cfg_row_i  in  ROW_WIDTH  row index.
- cfg_data_i  in  KEY_WIDTH  row value.
- cfg_ready_o  out  1  row write accepted this cycle.
- hash_valid_o  out  1  result valid.
- hash_ready_i  in  1  downstream accept.
- hash_adr_o  out  HASH_ADR_WIDTH  H3 hash result.
- hash_key_o  out  KEY_WIDTH  key that produced hash_adr_o.
- hash_id_o  out  ID_WIDTH  index of the originating requester.

REQ-003 The design SHALL have one clock domain (clk) and one asynchronous, active-high reset (rst).

Function
REQ-004 The block SHALL hold a HASH_ADR_WIDTH x KEY_WIDTH matrix register bank.
REQ-005 Hash bit j SHALL be the XOR-reduction of (key AND matrix row j).
REQ-006 Matrix row j SHALL reset to a one-hot value with bit j set, so the reset hash equals key[HASH_ADR_WIDTH-1:0].
REQ-007 The output stage SHALL be a 2-state FSM:
- EMPTY: hash_valid_o=0.
- FULL: hash_valid_o=1.
REQ-008 drain SHALL be defined as hash_valid_o AND hash_ready_i.
REQ-009 open SHALL be defined as (state==EMPTY) OR drain.
REQ-010 Arbitration SHALL be round-robin.
- A pointer ptr (ID_WIDTH bits) is kept.
- The winner is the first i with req_valid_i[i], searching ptr, ptr+1, ... with wrap modulo NUM_REQ.
REQ-011 req_ready_o[i] SHALL be 1 only for the winner, only when open=1 and cfg_we_i=0; at most one bit is set per cycle.
REQ-012 req_ready_o SHALL be combinational from inputs and state.
- A requester may hold req_valid_i without waiting for ready.
- Dropping req_valid_i before acceptance is legal.
REQ-013 On acceptance of requester g at edge N:
- hash_adr_o, hash_key_o and hash_id_o load the hash, key and g, using the matrix contents at edge N.
- The FSM goes to FULL.
- ptr becomes (g+1) mod NUM_REQ.
- Latency is 1 cycle: hash_valid_o=1 after edge N.
REQ-014 When drain occurs and nothing is accepted, the FSM SHALL go to EMPTY.
- A simultaneous drain and accept keeps the FSM in FULL with the new result.
- Throughput is 1 result per cycle.
REQ-015 While the FSM is FULL and hash_ready_i=0, all hash_* outputs SHALL hold stable and req_ready_o SHALL be 0.
REQ-016 cfg_ready_o SHALL equal cfg_we_i AND open.
- Configuration has priority over requests.
- While cfg_we_i=1, no request is granted and ptr holds.
REQ-017 On cfg_we_i AND cfg_ready_o, row cfg_row_i SHALL load cfg_data_i at that edge.
- If cfg_row_i >= HASH_ADR_WIDTH, the write is acknowledged and discarded.
- A result already in the output register is unaffected.
REQ-018 A key accepted on the cycle after a row write SHALL be hashed with the new row.
REQ-019 The output register SHALL only ever hold a result computed from one consistent matrix snapshot.

Reset
REQ-020 When rst=1, the following SHALL take effect immediately and asynchronously:
- FSM=EMPTY, hash_valid_o=0, hash_adr_o=0, hash_key_o=0, hash_id_o=0, ptr=0.
- Matrix returns to the identity of REQ-006.
- req_ready_o=0 and cfg_ready_o=0 while rst=1.
REQ-021 Reset mid-operation SHALL discard any pending result without a handshake.
- The first grant after release follows ptr=0 priority.

Verification
REQ-022 Reset hash: after reset, requester 2 sends key 0x0000_0013 with hash_ready_i=1 -> next cycle hash_valid_o=1, hash_adr_o=0x13, hash_key_o=0x0000_0013, hash_id_o=2.
REQ-023 Row write: write row 0 = 0xFFFF_FFFF, then requester 0 sends key 0x0000_0003 -> hash_adr_o=0x02.
REQ-024 Round-robin: all four req_valid_i=1 continuously with hash_ready_i=1 -> hash_id_o sequence 0,1,2,3,0,1, with one result per cycle.
REQ-025 Backpressure: with the FSM FULL (id 1), hold hash_ready_i=0 for 5 cycles while req_valid_i=4'b1111 -> outputs stable and req_ready_o=0 throughout; raising hash_ready_i drains id 1 and accepts id 2 in the same cycle.
REQ-026 Configuration contention:
- cfg_we_i=1 (row 3) while FULL with hash_ready_i=0 -> cfg_ready_o=0.
- When hash_ready_i=1 -> cfg_ready_o=1 and req_ready_o=0 that cycle.
- cfg_row_i=7 -> acknowledged, matrix unchanged.
REQ-027 Reset mid-operation: assert rst asynchronously while FULL with ptr=3 -> hash_valid_o=0 before the next edge; after release, requesters 0 and 3 valid -> requester 0 granted first.

Source files
------------

// File: rtl/h3_hash_scheduler.sv
// ---------------------------------------------------------------------------
// h3_hash_scheduler: round-robin arbiter feeding a programmable H3 hash with a
// one-entry registered output stage.                              Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module h3_hash_scheduler #(
  parameter int KEY_WIDTH      = 32,
  parameter int HASH_ADR_WIDTH = 5,
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQ),
  parameter int ROW_WIDTH      = $clog2(HASH_ADR_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [KEY_WIDTH-1:0]      req_key_i [NUM_REQ],
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      cfg_we_i,
  input  logic [ROW_WIDTH-1:0]      cfg_row_i,
  input  logic [KEY_WIDTH-1:0]      cfg_data_i,
  output logic                      cfg_ready_o,
  output logic                      hash_valid_o,
  input  logic                      hash_ready_i,
  output logic [HASH_ADR_WIDTH-1:0] hash_adr_o,
  output logic [KEY_WIDTH-1:0]      hash_key_o,
  output logic [ID_WIDTH-1:0]       hash_id_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [ID_WIDTH-1:0]       ptr_q, ptr_d;
  logic [HASH_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [KEY_WIDTH-1:0]      key_q, key_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [KEY_WIDTH-1:0]      matrix_q [HASH_ADR_WIDTH];

  logic                      drain;
  logic                      open_slot;
  logic                      accept;
  logic                      cfg_fire;
  logic                      grant_found;
  logic [ID_WIDTH-1:0]       grant_id;
  logic [KEY_WIDTH-1:0]      grant_key;
  logic [HASH_ADR_WIDTH-1:0] grant_hash;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid_i[ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_id    = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign grant_key = req_key_i[grant_id];

  generate
    for (genvar j = 0; j < HASH_ADR_WIDTH; j++) begin : g_hash
      assign grant_hash[j] = ^(grant_key & matrix_q[j]);
    end
  endgenerate

  // Reset also masks the handshakes so nothing is acknowledged while rst=1.
  assign drain       = (state_q == FULL) && hash_ready_i;
  assign open_slot   = !rst && ((state_q == EMPTY) || drain);
  assign cfg_fire    = cfg_we_i && open_slot;
  assign cfg_ready_o = cfg_fire;
  assign accept      = open_slot && !cfg_we_i && grant_found;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    adr_d        = adr_q;
    key_d        = key_q;
    id_d         = id_q;
    req_ready_o  = '0;
    hash_valid_o = (state_q == FULL);
    if (accept) begin
      req_ready_o = NUM_REQ'(1) << grant_id;
      state_d     = FULL;
      adr_d       = grant_hash;
      key_d       = grant_key;
      id_d        = grant_id;
      ptr_d       = ID_WIDTH'((int'(grant_id) + 1) % NUM_REQ);
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      adr_q   <= '0;
      key_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      adr_q   <= adr_d;
      key_q   <= key_d;
      id_q    <= id_d;
    end
  end

  // Out-of-range row indices match no row, so such writes vanish silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < HASH_ADR_WIDTH; j++) begin
        matrix_q[j] <= KEY_WIDTH'(1) << j;
      end
    end else if (cfg_fire) begin
      for (int j = 0; j < HASH_ADR_WIDTH; j++) begin
        if (cfg_row_i == ROW_WIDTH'(j)) begin
          matrix_q[j] <= cfg_data_i;
        end
      end
    end
  end

  assign hash_adr_o = adr_q;
  assign hash_key_o = key_q;
  assign hash_id_o  = id_q;

endmodule

`default_nettype wire

// File: tb/tb_h3_hash_scheduler.sv
// ---------------------------------------------------------------------------
// tb_h3_hash_scheduler: directed + random stimulus with a queue scoreboard and
// an abstract matrix/round-robin reference model.                 Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_h3_hash_scheduler;

  localparam int KW = 32;
  localparam int HW = 5;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid_i;
  logic [KW-1:0] req_key_i [NR];
  logic [NR-1:0] req_ready_o;
  logic          cfg_we_i;
  logic [RW-1:0] cfg_row_i;
  logic [KW-1:0] cfg_data_i;
  logic          cfg_ready_o;
  logic          hash_valid_o;
  logic          hash_ready_i;
  logic [HW-1:0] hash_adr_o;
  logic [KW-1:0] hash_key_o;
  logic [IW-1:0] hash_id_o;

  h3_hash_scheduler #(
    .KEY_WIDTH     (KW),
    .HASH_ADR_WIDTH(HW),
    .NUM_REQ       (NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_key_i   (req_key_i),
    .req_ready_o (req_ready_o),
    .cfg_we_i    (cfg_we_i),
    .cfg_row_i   (cfg_row_i),
    .cfg_data_i  (cfg_data_i),
    .cfg_ready_o (cfg_ready_o),
    .hash_valid_o(hash_valid_o),
    .hash_ready_i(hash_ready_i),
    .hash_adr_o  (hash_adr_o),
    .hash_key_o  (hash_key_o),
    .hash_id_o   (hash_id_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [HW-1:0] adr;
    logic [KW-1:0] key;
    logic [IW-1:0] id;
  } res_t;

  res_t          sb[$];
  logic [KW-1:0] m_mat [HW];
  int            m_ptr;
  bit            m_full;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < HW; j++) begin
      m_mat[j]    = '0;
      m_mat[j][j] = 1'b1;
    end
    m_ptr  = 0;
    m_full = 1'b0;
    sb.delete();
  endtask

  // Hash bit j is the parity of the key bits selected by row j.
  function automatic logic [HW-1:0] mhash(input logic [KW-1:0] key);
    logic [HW-1:0] h;
    int ones;
    for (int j = 0; j < HW; j++) begin
      ones = 0;
      for (int k = 0; k < KW; k++) if (key[k] && m_mat[j][k]) ones++;
      h[j] = ones[0];
    end
    return h;
  endfunction

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input logic [NR-1:0] v, input bit hr, input bit cw,
                      input logic [RW-1:0] crow, input logic [KW-1:0] cd);
    bit            drn, opn, acc;
    int            win;
    logic [NR-1:0] exp_rdy;
    res_t          r;
    req_valid_i  = v;
    hash_ready_i = hr;
    cfg_we_i     = cw;
    cfg_row_i    = crow;
    cfg_data_i   = cd;
    #3;
    check("hash_valid", 64'(hash_valid_o), 64'(m_full));
    drn = m_full && hr;
    opn = !m_full || drn;
    win = -1;
    for (int k = 0; k < NR; k++) if (win < 0 && v[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
    acc     = opn && !cw && (win >= 0);
    exp_rdy = acc ? NR'(1 << win) : '0;
    check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    check("cfg_ready", 64'(cfg_ready_o), 64'(cw && opn));
    if (acc) begin
      r.adr = mhash(req_key_i[win]);
      r.key = req_key_i[win];
      r.id  = IW'(win);
      sb.push_back(r);
      m_ptr  = (win + 1) % NR;
      m_full = 1'b1;
    end else if (drn) begin
      m_full = 1'b0;
    end
    if (cw && opn && int'(crow) < HW) m_mat[crow] = cd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: whenever a result is presented it must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst && hash_valid_o) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: result id %0d with nothing predicted at %0t", hash_id_o, $time);
      end else begin
        check("mon_adr", 64'(hash_adr_o), 64'(sb[0].adr));
        check("mon_key", 64'(hash_key_o), 64'(sb[0].key));
        check("mon_id",  64'(hash_id_o),  64'(sb[0].id));
        if (hash_ready_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst          = 1'b1;
    req_valid_i  = '0;
    hash_ready_i = 1'b0;
    cfg_we_i     = 1'b0;
    cfg_row_i    = '0;
    cfg_data_i   = '0;
    for (int i = 0; i < NR; i++) req_key_i[i] = '0;
    model_reset();
    #1;
    check("rst_valid", 64'(hash_valid_o), 64'd0);
    check("rst_adr",   64'(hash_adr_o),   64'd0);
    check("rst_key",   64'(hash_key_o),   64'd0);
    check("rst_id",    64'(hash_id_o),    64'd0);
    do_reset();

    // Identity matrix: hash is the low key bits.
    req_key_i[2] = 32'h0000_0013;
    step(4'b0100, 1'b1, 1'b0, '0, '0);
    check("rh_valid", 64'(hash_valid_o), 64'd1);
    check("rh_adr",   64'(hash_adr_o),   64'h13);
    check("rh_key",   64'(hash_key_o),   64'h13);
    check("rh_id",    64'(hash_id_o),    64'd2);
    step(4'b0000, 1'b1, 1'b0, '0, '0);

    // Row 0 all-ones then key 3 -> parity 0 in bit 0, bit 1 set.
    step(4'b0000, 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF);
    req_key_i[0] = 32'h0000_0003;
    step(4'b0001, 1'b1, 1'b0, '0, '0);
    check("rw_adr", 64'(hash_adr_o), 64'h02);
    step(4'b0000, 1'b1, 1'b0, '0, '0);

    // Round-robin at full throughput.
    do_reset();
    for (int i = 0; i < NR; i++) req_key_i[i] = 32'h1000_0000 * (i + 1) + i;
    for (int n = 0; n < 6; n++) begin
      step(4'b1111, 1'b1, 1'b0, '0, '0);
      check("rr_valid", 64'(hash_valid_o), 64'd1);
      check("rr_id",    64'(hash_id_o),    64'(n % NR));
    end

    // Backpressure: id 1 held, then drain+accept in one cycle.
    for (int n = 0; n < 5; n++) begin
      step(4'b1111, 1'b0, 1'b0, '0, '0);
      check("bp_id", 64'(hash_id_o), 64'd1);
    end
    step(4'b1111, 1'b1, 1'b0, '0, '0);
    check("bp_next_id", 64'(hash_id_o), 64'd2);

    // Configuration contention and out-of-range row.
    step(4'b0000, 1'b0, 1'b1, 3'd3, 32'h0000_0001);
    step(4'b1111, 1'b1, 1'b1, 3'd3, 32'h0000_0001);
    step(4'b0000, 1'b1, 1'b1, 3'd7, 32'hFFFF_FFFF);
    req_key_i[3] = 32'h0000_0001;
    step(4'b1000, 1'b1, 1'b0, '0, '0);
    check("cfg_adr", 64'(hash_adr_o), 64'h09);
    step(4'b0000, 1'b1, 1'b0, '0, '0);

    // Async reset while FULL with ptr=3.
    step(4'b0100, 1'b1, 1'b0, '0, '0);
    step(4'b1111, 1'b0, 1'b1, 3'd1, 32'h5);
    rst = 1'b1;
    #1;
    check("ar_valid", 64'(hash_valid_o), 64'd0);
    check("ar_id",    64'(hash_id_o),    64'd0);
    check("ar_rdy",   64'(req_ready_o),  64'd0);
    check("ar_cfg",   64'(cfg_ready_o),  64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b1001, 1'b1, 1'b0, '0, '0);
    check("ar_first_id", 64'(hash_id_o), 64'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) req_key_i[i] = $urandom;
      step(NR'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(9, 0) == 0),
           RW'($urandom), $urandom);
    end
    step(4'b0000, 1'b1, 1'b0, '0, '0);
    step(4'b0000, 1'b1, 1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
